pux_si_mc: RTL and testbench
============================

# pux_si_mc

Multi-channel operand sequencer for the cryhacc arithmetic core. It accepts one opcode per transaction and gathers a multi-word operand from each operand stream the opcode selects. It then starts the core, waits for it to finish, and returns one status word. It sits between the host AXI-Stream fabric and the modular-arithmetic core, and generalises the fixed A/B/M stream interface to NCH channels, WORDS limbs per operand and operand reuse.

## Interface
- OPCW, 8: opcode width; bits [NCH-1:0] are the channel mask, bits [OPCW-1:NCH] are the function code. Requires NCH < OPCW.
- DATAW, 16: beat and limb width; requires DATAW >= 11.
- NCH, 3: operand channel count (0=A, 1=B, 2=M by convention).
- WORDS, 4: limbs per operand, WORDS >= 1.
- TIMEOUT_CYC, 1024: core watchdog limit; used only with PUX_SI_MC_TIMEOUT_EN.

Ports:
- axis_clk  in  1  clock.
- axis_rst  in  1  reset, asynchronous and active-high.
- axis_opcode_data  in  OPCW  opcode beat.
- axis_opcode_valid / axis_opcode_ready  in / out  1  opcode handshake.
- axis_opnd_data  in  NCH*DATAW  per-channel beat; channel c is at [c*DATAW +: DATAW].
- axis_opnd_valid / axis_opnd_ready  in / out  NCH  per-channel handshake.
- axis_status_data  out  DATAW  status word.
- axis_status_valid / axis_status_ready  out / in  1  status handshake.
- stream_request  out  1  one-cycle pulse asking upstream to fetch the selected channels.
- stream_chmask  out  NCH  mask of the current transaction, valid with stream_request.
- core_start  out  1  one-cycle start pulse to the core.
- core_func  out  OPCW-NCH  latched function code.
- core_opnd  out  NCH*WORDS*DATAW  operand buffers; limb w of channel c is at [(c*WORDS+w)*DATAW +: DATAW].
- core_done  in  1  core completion pulse.
- core_err  in  1  core error flag, sampled together with core_done.

## Operation
- FSM states: IDLE, FETCH, START, WAIT, STATUS.
- IDLE:
  - axis_opcode_ready=1.
  - On an opcode handshake, latch the mask and function code and clear the per-channel beat counters.
  - Mask nonzero: go to FETCH and pulse stream_request on the next cycle.
  - Mask zero: go to STATUS with the empty flag set; no fetch and no core start.
- FETCH:
  - axis_opnd_ready[c] = sel[c] && cnt[c] != WORDS. It is driven from registers only and never depends on valid.
  - Beats arrive least-significant limb first; limb cnt[c] is written on each handshake.
  - Channels fill independently and in parallel.
  - When every selected counter equals WORDS, go to START.
- Unselected channels keep their previous buffer contents (for example, reusing the modulus M).
- START: core_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - core_done is sampled only in this state; it is ignored elsewhere.
  - On core_done, latch core_err and go to STATUS.
- STATUS:
  - axis_status_valid=1; data stays stable until the handshake.
  - On handshake, increment the sequence counter and go to IDLE.
- Status word bits:
  - [7:0] sequence number, mod 256.
  - [8] core_err.
  - [9] empty mask.
  - [10] timeout.
  - [DATAW-1:11] zero.
- core_opnd and core_func are stable from core_start until the next opcode is accepted.

## Timing
- Reset (asynchronous, any state):
  - FSM goes to IDLE; counters, sequence number and buffers are cleared to 0.
  - All ready, valid and pulse outputs are 0.
  - axis_opcode_ready is gated to 0 while axis_rst=1 and is 1 from the first cycle after release.
- Minimum latency, with all beats presented back-to-back:
  - Opcode accepted at cycle 0.
  - Beats accepted in cycles 1..WORDS.
  - core_start at cycle WORDS+1.
  - core_done at cycle k gives axis_status_valid at cycle k+1.
- Zero-mask opcode: axis_status_valid appears 1 cycle after acceptance.
- Valid held low stalls indefinitely without losing counter state.
- axis_opcode_ready=0 in every state except IDLE; the next opcode is accepted no earlier than the cycle after the status handshake.
- Beats on unselected channels are never accepted (ready stays 0).
- Sequence counter wraps 255 -> 0.

## Configuration
- PUX_SI_MC_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYC cycles pass without core_done, go to STATUS with bit 10=1 and bit 8=0.
  - A later core_done is ignored.
- Not defined: no counter exists, WAIT blocks indefinitely, and bit 10 is always 0.

## Structure
- Shared package pux_pkg holds:
  - FSM state encoding.
  - Status bit index constants: SEQ_LSB=0, ERR_BIT=8, EMPTY_BIT=9, TMO_BIT=10.
  - Opcode field helper constants.
- Sub-module pux_opnd_collect, one instance per channel via generate: beat counter, ready generation and WORDS-limb buffer.

## Test plan
- NCH=3, WORDS=4, opcode 0x07, beats A=1..4, B=5..8, M=9..12 → one stream_request pulse; core_start at cycle 5; core_opnd limbs match; core_done → status 0x0000.
- Opcode 0x03 after the above, A/B new values → M buffer still holds 9..12; status seq=1 (0x0001).
- Opcode 0x00 → no core_start, no stream_request; status 0x0200 one cycle after acceptance.
- Random valid gaps on channels and status_ready held low 10 cycles → no beat lost or duplicated; status data stable while stalled.
- core_err=1 with core_done → status bit 8 set. With PUX_SI_MC_TIMEOUT_EN, TIMEOUT_CYC=16 and no core_done → status 0x0400 after 16 WAIT cycles.
- axis_rst pulsed mid-FETCH (after 2 beats) → all outputs 0; the next transaction restarts at limb 0 with seq 0.

Source files
------------

// File: rtl/pux_pkg.sv
// Shared definitions for the pux_si_mc operand sequencer: FSM encoding,
// status-word bit positions and opcode field positions.
package pux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_WAIT,
        ST_STATUS
    } pux_state_e;

    localparam int SEQ_LSB       = 0;
    localparam int SEQ_W         = 8;
    localparam int ERR_BIT       = 8;
    localparam int EMPTY_BIT     = 9;
    localparam int TMO_BIT       = 10;
    localparam int STATUS_USED_W = 11;

    // The channel mask sits at the bottom of the opcode; the function code fills the bits above it.
    localparam int MASK_LSB = 0;

endpackage

// File: rtl/pux_opnd_collect.sv
// One operand channel: beat counter, ready generation and a WORDS-limb
// buffer filled least-significant limb first.
module pux_opnd_collect #(
    parameter int DATAW = 16,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic                   sel,
    input  logic                   beat_valid,
    input  logic [DATAW-1:0]       beat_data,
    output logic                   beat_ready,
    output logic                   full_nxt,
    output logic [WORDS*DATAW-1:0] limbs
);

    localparam int CW = $clog2(WORDS + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DATAW-1:0] buf_q [WORDS];
    logic [DATAW-1:0] buf_d [WORDS];
    logic             beat_hs;

    // Ready comes from flops only, so it never waits on valid.
    assign beat_ready = en && sel && (cnt_q != CW'(WORDS));
    assign beat_hs    = beat_ready && beat_valid;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (clear) begin
            cnt_d = '0;
        end else if (beat_hs) begin
            cnt_d = cnt_q + CW'(1);
            for (int w = 0; w < WORDS; w++) begin
                if (cnt_q == CW'(w)) begin
                    buf_d[w] = beat_data;
                end
            end
        end
    end

    // Looks one cycle ahead so the sequencer can leave FETCH on the last beat.
    assign full_nxt = (cnt_d == CW'(WORDS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            // NOTE: the limb buffer is reset on purpose: the core must see zeroed operands after reset, not stale data.
            for (int w = 0; w < WORDS; w++) begin
                buf_q[w] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    for (genvar w = 0; w < WORDS; w++) begin : g_limb
        assign limbs[w*DATAW +: DATAW] = buf_q[w];
    end

endmodule

// File: rtl/pux_si_mc.sv
// Multi-channel operand sequencer: opcode -> gather operands -> run core -> status word.
// Optional core watchdog enabled by defining PUX_SI_MC_TIMEOUT_EN.
module pux_si_mc
    import pux_pkg::*;
#(
    parameter int OPCW        = 8,
    parameter int DATAW       = 16,
    parameter int NCH         = 3,
    parameter int WORDS       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         axis_clk,
    input  logic                         axis_rst,
    input  logic [OPCW-1:0]              axis_opcode_data,
    input  logic                         axis_opcode_valid,
    output logic                         axis_opcode_ready,
    input  logic [NCH*DATAW-1:0]         axis_opnd_data,
    input  logic [NCH-1:0]               axis_opnd_valid,
    output logic [NCH-1:0]               axis_opnd_ready,
    output logic [DATAW-1:0]             axis_status_data,
    output logic                         axis_status_valid,
    input  logic                         axis_status_ready,
    output logic                         stream_request,
    output logic [NCH-1:0]               stream_chmask,
    output logic                         core_start,
    output logic [OPCW-NCH-1:0]          core_func,
    output logic [NCH*WORDS*DATAW-1:0]   core_opnd,
    input  logic                         core_done,
    input  logic                         core_err
);

    localparam int FUNCW = OPCW - NCH;

    if (NCH >= OPCW || DATAW < STATUS_USED_W || WORDS < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("pux_si_mc: unsupported parameter set");
    end

    pux_state_e       state_q, state_d;
    logic [NCH-1:0]   sel_q, sel_d;
    logic [FUNCW-1:0] func_q, func_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             err_q, err_d;
    logic             empty_q, empty_d;
    logic             tmo_q, tmo_d;
    logic             req_q, req_d;
    logic             opcode_hs;
    logic             fetch_en;
    logic             fetch_done;
    logic             tmo_hit;
    logic [NCH-1:0]   full_nxt;

    assign axis_opcode_ready = (state_q == ST_IDLE) && !axis_rst;
    assign opcode_hs         = axis_opcode_valid && axis_opcode_ready;
    assign fetch_en          = (state_q == ST_FETCH);
    assign fetch_done        = &(full_nxt | ~sel_q);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        pux_opnd_collect #(
            .DATAW (DATAW),
            .WORDS (WORDS)
        ) u_collect (
            .clk        (axis_clk),
            .rst        (axis_rst),
            .clear      (opcode_hs),
            .en         (fetch_en),
            .sel        (sel_q[c]),
            .beat_valid (axis_opnd_valid[c]),
            .beat_data  (axis_opnd_data[c*DATAW +: DATAW]),
            .beat_ready (axis_opnd_ready[c]),
            .full_nxt   (full_nxt[c]),
            .limbs      (core_opnd[c*WORDS*DATAW +: WORDS*DATAW])
        );
    end

`ifdef PUX_SI_MC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        sel_d             = sel_q;
        func_d            = func_q;
        seq_d             = seq_q;
        err_d             = err_q;
        empty_d           = empty_q;
        tmo_d             = tmo_q;
        req_d             = 1'b0;
        core_start        = 1'b0;
        axis_status_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (opcode_hs) begin
                    sel_d   = axis_opcode_data[MASK_LSB +: NCH];
                    func_d  = axis_opcode_data[OPCW-1:NCH];
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    empty_d = (axis_opcode_data[MASK_LSB +: NCH] == '0);
                    if (axis_opcode_data[MASK_LSB +: NCH] == '0) begin
                        state_d = ST_STATUS;
                    end else begin
                        req_d   = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (fetch_done) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                core_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (core_done) begin
                    err_d   = core_err;
                    state_d = ST_STATUS;
                end else if (tmo_hit) begin
                    err_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ST_STATUS;
                end
            end
            ST_STATUS: begin
                axis_status_valid = 1'b1;
                if (axis_status_ready) begin
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            func_q  <= '0;
            seq_q   <= '0;
            err_q   <= 1'b0;
            empty_q <= 1'b0;
            tmo_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            func_q  <= func_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
            empty_q <= empty_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        axis_status_data                     = '0;
        axis_status_data[SEQ_LSB +: SEQ_W]   = seq_q;
        axis_status_data[ERR_BIT]            = err_q;
        axis_status_data[EMPTY_BIT]          = empty_q;
        axis_status_data[TMO_BIT]            = tmo_q;
    end

    assign stream_request = req_q;
    assign stream_chmask  = sel_q;
    assign core_func      = func_q;

endmodule

// File: tb/tb_pux_si_mc.sv
// Self-checking bench for pux_si_mc: a directed vector table, randomized
// transactions against a spec-level model, reset and optional watchdog cases.
module tb_pux_si_mc;

    localparam int OPCW        = 8;
    localparam int DATAW       = 16;
    localparam int NCH         = 3;
    localparam int WORDS       = 4;
    localparam int TIMEOUT_CYC = 16;

    logic                       axis_clk = 1'b0;
    logic                       axis_rst;
    logic [OPCW-1:0]            axis_opcode_data;
    logic                       axis_opcode_valid;
    logic                       axis_opcode_ready;
    logic [NCH*DATAW-1:0]       axis_opnd_data;
    logic [NCH-1:0]             axis_opnd_valid;
    logic [NCH-1:0]             axis_opnd_ready;
    logic [DATAW-1:0]           axis_status_data;
    logic                       axis_status_valid;
    logic                       axis_status_ready;
    logic                       stream_request;
    logic [NCH-1:0]             stream_chmask;
    logic                       core_start;
    logic [OPCW-NCH-1:0]        core_func;
    logic [NCH*WORDS*DATAW-1:0] core_opnd;
    logic                       core_done;
    logic                       core_err;

    always #5 axis_clk = ~axis_clk;

    pux_si_mc #(
        .OPCW        (OPCW),
        .DATAW       (DATAW),
        .NCH         (NCH),
        .WORDS       (WORDS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .axis_clk          (axis_clk),
        .axis_rst          (axis_rst),
        .axis_opcode_data  (axis_opcode_data),
        .axis_opcode_valid (axis_opcode_valid),
        .axis_opcode_ready (axis_opcode_ready),
        .axis_opnd_data    (axis_opnd_data),
        .axis_opnd_valid   (axis_opnd_valid),
        .axis_opnd_ready   (axis_opnd_ready),
        .axis_status_data  (axis_status_data),
        .axis_status_valid (axis_status_valid),
        .axis_status_ready (axis_status_ready),
        .stream_request    (stream_request),
        .stream_chmask     (stream_chmask),
        .core_start        (core_start),
        .core_func         (core_func),
        .core_opnd         (core_opnd),
        .core_done         (core_done),
        .core_err          (core_err)
    );

    typedef struct {
        logic [OPCW-1:0]  opc;
        logic [DATAW-1:0] base;
        int               gap;
        int               stall;
        logic             err;
        int               dly;
        logic [DATAW-1:0] exp_status;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int req_cnt, req_cyc, start_cnt, start_cyc;
    int model_seq;

    logic [DATAW-1:0] model_buf [NCH][WORDS];
    logic [DATAW-1:0] beats     [NCH][WORDS];
    vec_t             vecs      [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
        cyc++;
        if (stream_request) begin
            req_cnt++;
            req_cyc = cyc;
        end
        if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
    endtask

    function automatic vec_t mk_vec(input logic [OPCW-1:0] opc, input logic [DATAW-1:0] base,
                                    input int gap, input int stall, input logic err, input int dly,
                                    input logic [DATAW-1:0] exp_status);
        vec_t v;
        v.opc        = opc;
        v.base       = base;
        v.gap        = gap;
        v.stall      = stall;
        v.err        = err;
        v.dly        = dly;
        v.exp_status = exp_status;
        return v;
    endfunction

    task automatic set_beats(input logic [DATAW-1:0] base);
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < WORDS; w++)
                beats[c][w] = base + DATAW'(c * WORDS + w + 1);
    endtask

    task automatic check_opnd(input string tag);
        logic [WORDS*DATAW-1:0] exp_l;
        for (int c = 0; c < NCH; c++) begin
            for (int w = 0; w < WORDS; w++) exp_l[w*DATAW +: DATAW] = model_buf[c][w];
            check($sformatf("%s_opnd_ch%0d", tag, c), 64'(core_opnd[c*WORDS*DATAW +: WORDS*DATAW]), 64'(exp_l));
        end
    endtask

    // Full transaction; dly < 0 means the core never answers (watchdog case).
    task automatic run_txn(input logic [OPCW-1:0] opc, input int gap_pct, input int stall,
                           input logic err, input int dly, input logic [DATAW-1:0] exp_status,
                           input string tag);
        logic [NCH-1:0]   sel, v, rdy, hs;
        logic [DATAW-1:0] first_status;
        logic             unsel_bad, stable, got;
        int               t0, last_hs, bound, remaining;
        sel       = opc[NCH-1:0];
        req_cnt   = 0;
        start_cnt = 0;
        req_cyc   = -1;
        start_cyc = -1;
        axis_opcode_data  = opc;
        axis_opcode_valid = 1'b1;
        bound = 0;
        while (!axis_opcode_ready && bound < 50) begin
            tick();
            bound++;
        end
        check({tag, "_opc_ready"}, axis_opcode_ready, 1'b1);
        t0 = cyc;
        tick();
        axis_opcode_valid = 1'b0;
        axis_opcode_data  = OPCW'($urandom);
        if (sel == '0) begin
            check({tag, "_empty_status_lat"}, axis_status_valid, 1'b1);
        end else begin
            v         = '0;
            unsel_bad = 1'b0;
            last_hs   = -1;
            remaining = 0;
            for (int c = 0; c < NCH; c++) if (sel[c]) remaining += WORDS;
            int_idx_loop: begin
                int idx [NCH];
                for (int c = 0; c < NCH; c++) idx[c] = 0;
                bound = 0;
                while (remaining > 0 && bound < 400) begin
                    for (int c = 0; c < NCH; c++) begin
                        if (sel[c]) begin
                            if (idx[c] < WORDS) begin
                                if (!v[c]) v[c] = ($urandom_range(99) >= gap_pct);
                                axis_opnd_data[c*DATAW +: DATAW] = beats[c][idx[c]];
                            end
                        end else begin
                            v[c] = 1'($urandom_range(1));
                            axis_opnd_data[c*DATAW +: DATAW] = DATAW'($urandom);
                        end
                    end
                    axis_opnd_valid = v;
                    core_done = ($urandom_range(7) == 0);
                    core_err  = 1'b1;
                    rdy = axis_opnd_ready;
                    if ((rdy & ~sel) != '0) unsel_bad = 1'b1;
                    hs = rdy & v;
                    if (hs != '0) last_hs = cyc;
                    tick();
                    for (int c = 0; c < NCH; c++) begin
                        if (hs[c]) begin
                            idx[c]++;
                            v[c] = 1'b0;
                            remaining--;
                        end
                    end
                    bound++;
                end
            end
            axis_opnd_valid = '0;
            core_done       = 1'b0;
            core_err        = 1'b0;
            check({tag, "_beats_remaining"}, 64'(remaining), 64'd0);
            check({tag, "_unsel_ready"}, unsel_bad, 1'b0);
            if (gap_pct == 0) check({tag, "_last_beat_cyc"}, 64'(last_hs - t0), 64'(WORDS));
            bound = 0;
            while (start_cnt == 0 && bound < 20) begin
                tick();
                bound++;
            end
            check({tag, "_start_after_beats"}, 64'(start_cyc - last_hs), 64'd1);
            check({tag, "_req_cyc"}, 64'(req_cyc - t0), 64'd1);
            check({tag, "_chmask"}, 64'(stream_chmask), 64'(sel));
            check({tag, "_func"}, 64'(core_func), 64'(opc[OPCW-1:NCH]));
            for (int c = 0; c < NCH; c++)
                if (sel[c])
                    for (int w = 0; w < WORDS; w++) model_buf[c][w] = beats[c][w];
            check_opnd(tag);
            tick();
            if (dly >= 0) begin
                repeat (dly) tick();
                check({tag, "_no_early_status"}, axis_status_valid, 1'b0);
                core_done = 1'b1;
                core_err  = err;
                tick();
                core_done = 1'b0;
                core_err  = 1'b0;
                check({tag, "_status_lat"}, axis_status_valid, 1'b1);
            end else begin
                bound = 0;
                while (!axis_status_valid && bound < 100) begin
                    tick();
                    bound++;
                end
                check({tag, "_tmo_lat"}, 64'(cyc - start_cyc), 64'(TIMEOUT_CYC + 1));
            end
        end
        first_status = axis_status_data;
        check({tag, "_status"}, 64'(first_status), 64'(exp_status));
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (i == 0) begin
                core_done = 1'b1;
                core_err  = ~err;
            end
            tick();
            core_done = 1'b0;
            core_err  = 1'b0;
            if (!axis_status_valid || axis_status_data !== first_status) stable = 1'b0;
        end
        if (stall > 0) check({tag, "_status_stable"}, stable, 1'b1);
        axis_status_ready = 1'b1;
        tick();
        axis_status_ready = 1'b0;
        got = axis_status_valid;
        check({tag, "_status_drop"}, got, 1'b0);
        check({tag, "_back_idle"}, axis_opcode_ready, 1'b1);
        check({tag, "_req_count"}, 64'(req_cnt), 64'(sel != '0));
        check({tag, "_start_count"}, 64'(start_cnt), 64'(sel != '0));
        model_seq = (model_seq + 1) % 256;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_opc_ready"}, axis_opcode_ready, 1'b0);
        check({tag, "_opnd_ready"}, 64'(axis_opnd_ready), 64'd0);
        check({tag, "_status_valid"}, axis_status_valid, 1'b0);
        check({tag, "_req"}, stream_request, 1'b0);
        check({tag, "_start"}, core_start, 1'b0);
        check({tag, "_opnd_zero"}, |core_opnd, 1'b0);
        check({tag, "_status_data"}, 64'(axis_status_data), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATAW-1:0] e;
        logic [OPCW-1:0]  opc;
        logic             err;
        axis_rst          = 1'b1;
        axis_opcode_data  = '0;
        axis_opcode_valid = 1'b0;
        axis_opnd_data    = '0;
        axis_opnd_valid   = '0;
        axis_status_ready = 1'b0;
        core_done         = 1'b0;
        core_err          = 1'b0;
        model_seq         = 0;
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < WORDS; w++) model_buf[c][w] = '0;

        #12;
        check_quiet("reset");
        @(posedge axis_clk);
        #1 axis_rst = 1'b0;
        #1 check("release_opc_ready", axis_opcode_ready, 1'b1);
        tick();

        vecs[0] = mk_vec(8'h07, 16'h0000,  0,  0, 1'b0, 0, 16'h0000);
        vecs[1] = mk_vec(8'h03, 16'h0020,  0,  0, 1'b0, 2, 16'h0001);
        vecs[2] = mk_vec(8'h00, 16'h0000,  0,  0, 1'b0, 0, 16'h0202);
        vecs[3] = mk_vec(8'h0B, 16'h0030,  0,  2, 1'b1, 3, 16'h0103);
        vecs[4] = mk_vec(8'h02, 16'h0050, 40, 10, 1'b0, 1, 16'h0004);
        vecs[5] = mk_vec(8'hF8, 16'h0000,  0,  3, 1'b0, 0, 16'h0205);
        vecs[6] = mk_vec(8'h01, 16'h0060, 60,  0, 1'b1, 0, 16'h0106);
        for (int i = 0; i < 7; i++) begin
            set_beats(vecs[i].base);
            run_txn(vecs[i].opc, vecs[i].gap, vecs[i].stall, vecs[i].err, vecs[i].dly,
                    vecs[i].exp_status, $sformatf("vec%0d", i));
        end
        check("m_reuse", 64'(core_opnd[2*WORDS*DATAW +: WORDS*DATAW]), 64'h000C_000B_000A_0009);

        for (int n = 0; n < 260; n++) begin
            opc = OPCW'($urandom_range(255));
            err = 1'($urandom_range(1));
            for (int c = 0; c < NCH; c++)
                for (int w = 0; w < WORDS; w++) beats[c][w] = DATAW'($urandom);
            e = DATAW'(model_seq);
            if (opc[NCH-1:0] == '0) e[9] = 1'b1;
            else if (err) e[8] = 1'b1;
            run_txn(opc, $urandom_range(70), $urandom_range(5), err, $urandom_range(6), e,
                    $sformatf("rnd%0d", n));
        end

        set_beats(16'h0070);
        axis_opcode_data  = 8'h07;
        axis_opcode_valid = 1'b1;
        check("mid_rst_opc_ready", axis_opcode_ready, 1'b1);
        tick();
        axis_opcode_valid = 1'b0;
        for (int w = 0; w < 2; w++) begin
            axis_opnd_valid = '1;
            for (int c = 0; c < NCH; c++) axis_opnd_data[c*DATAW +: DATAW] = beats[c][w];
            tick();
        end
        axis_opnd_valid = '0;
        axis_rst = 1'b1;
        #1 check_quiet("mid_rst");
        tick();
        tick();
        check("mid_rst_held_opc_ready", axis_opcode_ready, 1'b0);
        axis_rst = 1'b0;
        #1 check("mid_rst_release", axis_opcode_ready, 1'b1);
        model_seq = 0;
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < WORDS; w++) model_buf[c][w] = '0;
        set_beats(16'h0080);
        run_txn(8'h01, 0, 0, 1'b0, 0, 16'h0000, "post_rst_a");
        set_beats(16'h0090);
        run_txn(8'h07, 0, 0, 1'b0, 1, 16'h0001, "post_rst_all");

`ifdef PUX_SI_MC_TIMEOUT_EN
        set_beats(16'h00A0);
        run_txn(8'h07, 0, 3, 1'b1, -1, 16'h0402, "timeout");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
